// File: rtl/light_pkg.sv
// Shared types and constants for the light show sequencer.
// Holds the state encoding, step counts and the switch-to-pattern map.
package light_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LEFT  = 2'b01,
        RIGHT = 2'b10,
        BLINK = 2'b11
    } state_t;

    localparam logic [1:0] MODE_IDLE  = 2'b00;
    localparam logic [1:0] MODE_LEFT  = 2'b01;
    localparam logic [1:0] MODE_RIGHT = 2'b10;
    localparam logic [1:0] MODE_BLINK = 2'b11;

    localparam logic [4:0] LEFT_STEPS  = 5'd16;
    localparam logic [4:0] RIGHT_STEPS = 5'd16;
    localparam logic [4:0] BLINK_STEPS = 5'd8;

    function automatic logic [15:0] sw_pattern(input logic [2:0] sw);
        logic [4:0] n;
        n = {2'b00, sw} + 5'd1;
        return (16'd1 << n) - 16'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button synchronizer and debouncer.
// Emits a one-cycle press pulse on the accepted rising edge.
module btn_debounce #(
    parameter int CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int CW = $clog2(CYCLES + 1);

    logic          s1;
    logic          s2;
    logic          level;
    logic [1:0]    fill;
    logic          armed;
    logic [CW-1:0] cnt;
    logic          accept;

    assign accept = (s2 != level) && (cnt == CW'(CYCLES - 1));

    // A button held through reset is absorbed silently; pulses resume
    // only once a released level has been seen after the sync chain fills.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            level <= 1'b0;
            fill  <= 2'b00;
            armed <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            s1    <= btn;
            s2    <= s1;
            fill  <= {fill[0], 1'b1};
            press <= accept && s2 && armed;
            if (s2 != level) begin
                if (accept) begin
                    level <= s2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
            if (fill[1] && !s2 && !level)
                armed <= 1'b1;
        end
    end

endmodule

// File: rtl/light_show_sequencer.sv
// Light show sequencer: left sweep, right sweep, blink, repeat.
// Buttons start and stop the show; switch picks the pattern width.
module light_show_sequencer #(
    parameter int TICK_CYCLES     = 100000000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start,
    input  logic        btn_stop,
    input  logic [2:0]  switch,
    input  logic [1:0]  speed,
    output logic [15:0] led,
    output logic        busy,
    output logic [1:0]  mode
);

    import light_pkg::*;

    state_t      state;
    state_t      state_n;
    logic [15:0] led_n;
    logic [15:0] hold;
    logic [15:0] hold_n;
    logic [31:0] tick_cnt;
    logic [31:0] tick_cnt_n;
    logic [4:0]  step;
    logic [4:0]  step_n;
    logic [31:0] lim;
    logic [31:0] lim_m1;
    logic        tick;
    logic        start_p;
    logic        stop_p;

    btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_start (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_start),
        .press (start_p)
    );

    btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_stop (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_stop),
        .press (stop_p)
    );

    // A period that shifts down to zero still steps once per cycle.
    assign lim    = 32'(TICK_CYCLES) >> speed;
    assign lim_m1 = (lim == 32'd0) ? 32'd0 : lim - 32'd1;
    assign tick   = (tick_cnt >= lim_m1);

    always_comb begin
        state_n    = state;
        led_n      = led;
        hold_n     = hold;
        step_n     = step;
        tick_cnt_n = tick ? 32'd0 : tick_cnt + 32'd1;
        unique case (state)
            IDLE: begin
                led_n      = sw_pattern(switch);
                tick_cnt_n = 32'd0;
                step_n     = 5'd0;
                if (start_p && !stop_p) begin
                    state_n = LEFT;
                    hold_n  = sw_pattern(switch);
                end
            end
            LEFT: begin
                if (tick) begin
                    led_n  = {led[14:0], led[15]};
                    step_n = step + 5'd1;
                    if (step == LEFT_STEPS - 5'd1)
                        state_n = RIGHT;
                end
            end
            RIGHT: begin
                if (tick) begin
                    led_n  = {led[0], led[15:1]};
                    step_n = step + 5'd1;
                    if (step == RIGHT_STEPS - 5'd1)
                        state_n = BLINK;
                end
            end
            BLINK: begin
                if (tick) begin
                    led_n  = step[0] ? hold : 16'h0000;
                    step_n = step + 5'd1;
                    if (step == BLINK_STEPS - 5'd1)
                        state_n = LEFT;
                end
            end
        endcase
        if (state != IDLE && stop_p) begin
            state_n = IDLE;
            led_n   = led;
        end
        if (state_n != state) begin
            tick_cnt_n = 32'd0;
            step_n     = 5'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            led      <= 16'h0001;
            hold     <= 16'h0001;
            tick_cnt <= 32'd0;
            step     <= 5'd0;
        end else begin
            state    <= state_n;
            led      <= led_n;
            hold     <= hold_n;
            tick_cnt <= tick_cnt_n;
            step     <= step_n;
        end
    end

    always_comb begin
        mode = MODE_IDLE;
        unique case (state)
            IDLE:  mode = MODE_IDLE;
            LEFT:  mode = MODE_LEFT;
            RIGHT: mode = MODE_RIGHT;
            BLINK: mode = MODE_BLINK;
        endcase
    end

    assign busy = (state != IDLE);

endmodule
